// File: rtl/idex_pkg.sv
// Shared types and constants for the ID/EX stage register: payload layout,
// default field widths and the handshake FSM state encoding.
package idex_pkg;

  localparam int XLEN   = 32;
  localparam int SRCA_W = 2;
  localparam int SRCB_W = 3;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  // Field order matches the flat vector packed by the top: selects in the low bits.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1val;
    logic [XLEN-1:0]   rs2val;
    logic [XLEN-1:0]   ls_jal_addr;
    logic [XLEN-1:0]   auipc_lui;
    logic [XLEN-1:0]   ls32_addr;
    logic [SRCA_W-1:0] alu_src_a;
    logic [SRCB_W-1:0] alu_src_b;
  } idex_payload_t;

endpackage

// File: rtl/idex_slot.sv
// One payload register: full synchronous clear, a select-only clear that leaves
// the wide fields untouched, and a load enable.
module idex_slot
  import idex_pkg::*;
#(
  parameter int W     = 197,
  parameter int SEL_W = 5
) (
  input  logic         CLK,
  input  logic         srst,
  input  logic         clr_sel,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_reg;

  always_ff @(posedge CLK) begin
    if (srst) begin
      data_reg <= '0;
    end else if (clr_sel) begin
      // Only the ALU selects are zeroed; the rest is don't-care while invalid.
      data_reg[SEL_W-1:0] <= '0;
    end else if (load) begin
      data_reg <= d;
    end
  end

  assign q = data_reg;

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX stage register with valid/ready handshake, flush and an optional skid
// slot so decode sees a registered ready while execute stalls.
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter int XLEN   = idex_pkg::XLEN,
  parameter int SRCA_W = idex_pkg::SRCA_W,
  parameter int SRCB_W = idex_pkg::SRCB_W,
  parameter int SKID   = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   InPC,
  input  logic [XLEN-1:0]   Inrs1val,
  input  logic [XLEN-1:0]   Inrs2val,
  input  logic [XLEN-1:0]   InLoadStoreOrjalAddress,
  input  logic [XLEN-1:0]   InauipcOrlui,
  input  logic [XLEN-1:0]   InLoadStore32Address,
  input  logic [SRCA_W-1:0] InALUSourceA,
  input  logic [SRCB_W-1:0] InALUSourceB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   PC,
  output logic [XLEN-1:0]   rs1val,
  output logic [XLEN-1:0]   rs2val,
  output logic [XLEN-1:0]   LoadStoreOrjalAddress,
  output logic [XLEN-1:0]   auipcOrlui,
  output logic [XLEN-1:0]   LoadStore32Address,
  output logic [SRCA_W-1:0] ALUSourceA,
  output logic [SRCB_W-1:0] ALUSourceB
);

  localparam int SEL_W = SRCA_W + SRCB_W;
  localparam int PW    = 6 * XLEN + SEL_W;

  logic [1:0]    state_reg;
  logic [1:0]    state_next;
  logic          rst_done_reg;
  logic          accept;
  logic          main_load;
  logic          main_clr_sel;
  logic          main_from_skid;
  logic          skid_load;
  logic [PW-1:0] in_flat;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;

  assign in_flat = {InPC, Inrs1val, Inrs2val, InLoadStoreOrjalAddress,
                    InauipcOrlui, InLoadStore32Address, InALUSourceA, InALUSourceB};

  assign {PC, rs1val, rs2val, LoadStoreOrjalAddress,
          auipcOrlui, LoadStore32Address, ALUSourceA, ALUSourceB} = main_q;

  // rst_done_reg holds in_ready low through reset without a path from RST itself.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_EMPTY;
      rst_done_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rst_done_reg <= 1'b1;
    end
  end

  assign out_valid = (state_reg != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? (rst_done_reg && (state_reg != ST_SKID))
                                 : (rst_done_reg && (!out_valid || out_ready));
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_FULL;
        ST_FULL: begin
          if (out_ready) begin
            state_next = accept ? ST_FULL : ST_EMPTY;
          end else if (accept && (SKID != 0)) begin
            state_next = ST_SKID;
          end
        end
        ST_SKID:  if (out_ready) state_next = ST_FULL;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    main_clr_sel   = flush;
    if (!flush) begin
      case (state_reg)
        ST_EMPTY: main_load = accept;
        ST_FULL: begin
          main_load = accept && out_ready;
          skid_load = accept && !out_ready;
        end
        ST_SKID: begin
          main_load      = out_ready;
          main_from_skid = 1'b1;
        end
        default: main_load = 1'b0;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_flat;

  idex_slot #(.W(PW), .SEL_W(SEL_W)) u_main (
    .CLK     (CLK),
    .srst    (RST),
    .clr_sel (main_clr_sel),
    .load    (main_load),
    .d       (main_d),
    .q       (main_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      idex_slot #(.W(PW), .SEL_W(SEL_W)) u_skid (
        .CLK     (CLK),
        .srst    (RST),
        .clr_sel (1'b0),
        .load    (skid_load),
        .d       (in_flat),
        .q       (skid_q)
      );
    end else begin : g_no_skid
      assign skid_q = '0;
    end
  endgenerate

endmodule

// File: tb/tb_idex_pipe_reg.sv
// Drives a SKID=0 and a SKID=1 instance with shared stimulus and checks both
// against a queue-based model of the stage's occupancy and ordering.
module tb_idex_pipe_reg;
  import idex_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  idex_payload_t cur_in = '0;

  logic              o_ready [2];
  logic              o_valid [2];
  logic [XLEN-1:0]   o_pc    [2];
  logic [XLEN-1:0]   o_rs1   [2];
  logic [XLEN-1:0]   o_rs2   [2];
  logic [XLEN-1:0]   o_lsj   [2];
  logic [XLEN-1:0]   o_aul   [2];
  logic [XLEN-1:0]   o_ls32  [2];
  logic [SRCA_W-1:0] o_sa    [2];
  logic [SRCB_W-1:0] o_sb    [2];

  int tests = 0;
  int fails = 0;

  idex_payload_t mq [2][$];
  idex_payload_t exp_pl [2];
  bit            rd [2];
  bit            pre_rdy [2];

  initial forever #5 CLK = ~CLK;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      idex_pipe_reg #(.XLEN(XLEN), .SRCA_W(SRCA_W), .SRCB_W(SRCB_W), .SKID(gi)) u_dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .flush                   (flush),
        .in_valid                (in_valid),
        .in_ready                (o_ready[gi]),
        .InPC                    (cur_in.pc),
        .Inrs1val                (cur_in.rs1val),
        .Inrs2val                (cur_in.rs2val),
        .InLoadStoreOrjalAddress (cur_in.ls_jal_addr),
        .InauipcOrlui            (cur_in.auipc_lui),
        .InLoadStore32Address    (cur_in.ls32_addr),
        .InALUSourceA            (cur_in.alu_src_a),
        .InALUSourceB            (cur_in.alu_src_b),
        .out_valid               (o_valid[gi]),
        .out_ready               (out_ready),
        .PC                      (o_pc[gi]),
        .rs1val                  (o_rs1[gi]),
        .rs2val                  (o_rs2[gi]),
        .LoadStoreOrjalAddress   (o_lsj[gi]),
        .auipcOrlui              (o_aul[gi]),
        .LoadStore32Address      (o_ls32[gi]),
        .ALUSourceA              (o_sa[gi]),
        .ALUSourceB              (o_sb[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic idex_payload_t obs_pl(input int k);
    idex_payload_t p;
    p.pc          = o_pc[k];
    p.rs1val      = o_rs1[k];
    p.rs2val      = o_rs2[k];
    p.ls_jal_addr = o_lsj[k];
    p.auipc_lui   = o_aul[k];
    p.ls32_addr   = o_ls32[k];
    p.alu_src_a   = o_sa[k];
    p.alu_src_b   = o_sb[k];
    return p;
  endfunction

  // Capacity two with skid (ready from occupancy only), capacity one without
  // (ready also when the held entry leaves this cycle).
  function automatic bit model_ready(input int k);
    if (!rd[k]) return 1'b0;
    if (k == 1) return mq[k].size() < 2;
    return (mq[k].size() == 0) || out_ready;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (RST) begin
        mq[k].delete();
        rd[k]     = 1'b0;
        exp_pl[k] = '0;
      end else if (flush) begin
        mq[k].delete();
        rd[k] = 1'b1;
        exp_pl[k].alu_src_a = '0;
        exp_pl[k].alu_src_b = '0;
      end else begin
        if (out_ready && mq[k].size() > 0) begin
          idex_payload_t h;
          h = mq[k].pop_front();
          $display("[TB] skid=%0d out pc=%08h rs1=%08h", k, h.pc, h.rs1val);
        end
        if (in_valid && pre_rdy[k]) mq[k].push_back(cur_in);
        rd[k] = 1'b1;
        if (mq[k].size() > 0) exp_pl[k] = mq[k][0];
      end
    end
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      pre_rdy[k] = model_ready(k);
      check($sformatf("in_ready_pre%0d", k), o_ready[k], pre_rdy[k]);
    end
    @(posedge CLK);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("out_valid%0d", k), o_valid[k], mq[k].size() > 0);
      check($sformatf("payload%0d", k), obs_pl(k), exp_pl[k]);
    end
  endtask

  task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] rs1);
    in_valid             = v;
    cur_in.pc            = pc;
    cur_in.rs1val        = rs1;
    cur_in.rs2val        = $urandom;
    cur_in.ls_jal_addr   = $urandom;
    cur_in.auipc_lui     = $urandom;
    cur_in.ls32_addr     = $urandom;
    cur_in.alu_src_a     = SRCA_W'($urandom_range(0, 3));
    cur_in.alu_src_b     = SRCB_W'($urandom_range(0, 7));
  endtask

  initial begin
    RST = 1'b1;
    @(posedge CLK);
    #1;
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      rd[k]     = 1'b0;
      exp_pl[k] = '0;
    end

    // reset state
    step();
    check("rst_valid", o_valid[1], 1'b0);
    check("rst_ready", o_ready[1], 1'b0);
    check("rst_pc", o_pc[1], 32'h0);
    RST = 1'b0;
    step();
    check("ready_after_rst1", o_ready[1], 1'b1);
    check("ready_after_rst0", o_ready[0], 1'b1);

    // single transfer
    out_ready = 1'b1;
    set_in(1'b1, 32'h100, 32'd5);
    step();
    check("single_valid", o_valid[1], 1'b1);
    check("single_pc", o_pc[1], 32'h100);
    check("single_rs1", o_rs1[1], 32'd5);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    check("single_drain", o_valid[1], 1'b0);

    // back-to-back stream
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'(i * 4), 32'(i));
      step();
      check("stream_pc1", o_pc[1], 32'(i * 4));
      check("stream_pc0", o_pc[0], 32'(i * 4));
      check("stream_ready1", o_ready[1], 1'b1);
    end
    set_in(1'b0, 32'h0, 32'h0);
    step();

    // stall fills the skid slot, release drains in order
    out_ready = 1'b0;
    set_in(1'b1, 32'h10, 32'd1);
    step();
    set_in(1'b1, 32'h14, 32'd2);
    step();
    check("stall_hold_pc", o_pc[1], 32'h10);
    check("stall_ready", o_ready[1], 1'b0);
    set_in(1'b0, 32'h0, 32'h0);
    step();
    check("stall_still_pc", o_pc[1], 32'h10);
    out_ready = 1'b1;
    step();
    check("release_pc", o_pc[1], 32'h14);
    check("release_ready", o_ready[1], 1'b1);
    step();
    check("release_drain", o_valid[1], 1'b0);

    // flush while in SKID state
    out_ready = 1'b0;
    set_in(1'b1, 32'h20, 32'd3);
    step();
    set_in(1'b1, 32'h24, 32'd4);
    step();
    set_in(1'b1, 32'h28, 32'd5);
    flush = 1'b1;
    step();
    check("flush_valid", o_valid[1], 1'b0);
    check("flush_srca", o_sa[1], 2'd0);
    check("flush_srcb", o_sb[1], 3'd0);
    check("flush_ready", o_ready[1], 1'b1);
    flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_emit", o_valid[1], 1'b0);

    // reset in the middle of a stall
    out_ready = 1'b0;
    set_in(1'b1, 32'h30, 32'd6);
    step();
    set_in(1'b1, 32'h34, 32'd7);
    step();
    check("pre_rst_valid", o_valid[1], 1'b1);
    RST = 1'b1;
    set_in(1'b0, 32'h0, 32'h0);
    step();
    check("midrst_valid", o_valid[1], 1'b0);
    check("midrst_pc", o_pc[1], 32'h0);
    check("midrst_ready", o_ready[1], 1'b0);
    step();
    check("midrst_ready_hold", o_ready[1], 1'b0);
    RST = 1'b0;
    step();
    check("midrst_ready_back", o_ready[1], 1'b1);

    // single-entry build: combinational ready and same-edge reload
    out_ready = 1'b0;
    set_in(1'b1, 32'h40, 32'd8);
    step();
    set_in(1'b1, 32'h44, 32'd9);
    #1;
    check("noskid_stall_ready", o_ready[0], 1'b0);
    out_ready = 1'b1;
    #1;
    check("noskid_release_ready", o_ready[0], 1'b1);
    step();
    check("noskid_reload_pc", o_pc[0], 32'h44);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      RST       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_in($urandom_range(0, 3) != 0, $urandom, $urandom);
      step();
    end
    RST   = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
